exception_sequencer: RTL and testbench
======================================

// Module: exception_sequencer
// PURPOSE
// - Multicycle FSM that runs the exception entry sequence; sits upstream of the memory-address select mux.
// - Latches a raised cause and saves EPC = PC - PC_OFFSET.
// - Drives the address-select code for the cause's vector slot (0x253/0x254/0x255) and reads the handler byte.
// - Loads PC with the zero-extended byte and hands the datapath back to the main control unit.
// PARAMETERS
// - MEM_WAIT   2     read-latency cycles between mem_rd assertion and valid mem_data
// - PC_OFFSET  4     value subtracted from pc_in to form EPC
// - SEL_OVF    3'd2  address-select code for the overflow vector (0x253)
// - SEL_DIVZ   3'd3  address-select code for the divide-by-zero vector (0x254)
// - SEL_OPC    3'd4  address-select code for the invalid-opcode vector (0x255)
// PORTS
// - clk        in   1   single clock, rising edge
// - reset      in   1   synchronous, active-high
// - overflow   in   1   ALU overflow flag, sampled only in IDLE
// - div_zero   in   1   divider zero-divisor flag, sampled only in IDLE
// - bad_opcode in   1   decoder invalid-opcode flag, sampled only in IDLE
// - pc_in      in   32  current PC register value
// - mem_data   in   32  memory read data; byte [7:0] valid MEM_WAIT cycles after mem_rd
// - exc_busy   out  1   sequencer owns address select, memory and PC; main control stalls
// - exc_sel    out  3   address-select code; top level uses it while exc_busy=1
// - mem_rd     out  1   memory read strobe
// - epc_wr     out  1   EPC write enable, 1-cycle pulse
// - epc_out    out  32  EPC value: pc_in - PC_OFFSET captured at entry
// - cause      out  2   latched cause: 0 none, 1 overflow, 2 div_zero, 3 bad_opcode
// - pc_wr      out  1   PC write enable, 1-cycle pulse
// - pc_next    out  32  {24'b0, mem_data[7:0]} captured at end of WAIT
// - exc_done   out  1   1-cycle pulse; main control resumes next cycle
// BEHAVIOUR
// - Reset values (on reset, from any state): state=IDLE; every output 0, including epc_out, cause, pc_next and exc_sel=3'd0.
// - IDLE: exc_busy=0. If any flag is high, go to SAVE.
//   - Latch cause using priority bad_opcode > overflow > div_zero.
//   - Capture epc_out = pc_in - PC_OFFSET. Arithmetic is modulo 2^32, so pc_in=0 gives 0xFFFFFFFC.
// - SAVE (1 cycle): exc_busy=1, epc_wr=1.
// - ADDR (1 cycle): exc_sel=code for cause, mem_rd=1. Wait counter loads MEM_WAIT-1.
// - WAIT: exc_sel and mem_rd held. Counter decrements each cycle.
//   - At counter=0, capture pc_next and go to LOAD.
//   - MEM_WAIT=1 means exactly one WAIT cycle.
// - LOAD (1 cycle): pc_wr=1, mem_rd=0, exc_sel still driven.
// - DONE (1 cycle): exc_done=1, exc_busy=1; then IDLE. cause and epc_out hold until the next entry.
// - Total latency from flag sampled to exc_done: 4 + MEM_WAIT cycles. exc_busy is high for exactly that many cycles.
// - Flags raised while not in IDLE are ignored, not queued. Nested exceptions are not supported.
// - A flag held high through DONE re-enters on the first IDLE cycle. Control must clear its flags by DONE.
// - Reset asserted mid-sequence aborts immediately. No pc_wr is issued, and a partial epc_out is cleared.
// - exc_sel is 3'd0 whenever exc_busy=0.
// STRUCTURE
// - Shared package (`define header): state encodings, cause codes, and SEL_* select codes.
//   - The SEL_* codes are shared with the address mux and the main control unit.
// - Single module; the wait counter is inline. No sub-module.
// - Width of the wait counter is $clog2(MEM_WAIT+1).
// TESTING
// - Overflow case. Stimulus: overflow=1 for 1 cycle, pc_in=0x40, mem_data=0x0000_00A7.
//   Response: epc_out=0x3C, epc_wr pulse, exc_sel=2, pc_next=0xA7, pc_wr, exc_done at cycle 6, cause=1.
// - Simultaneous flags. Stimulus: overflow=1, div_zero=1, bad_opcode=1 together.
//   Response: cause=3, exc_sel=4 for the whole ADDR..LOAD window.
// - Wrap-around. Stimulus: div_zero=1, pc_in=0x0, mem_data=0xFFFF_FF12.
//   Response: epc_out=0xFFFF_FFFC, pc_next=0x12, exc_sel=3.
// - Flag while busy. Stimulus: bad_opcode pulse, then overflow pulse 2 cycles later.
//   Response: single sequence with cause=3, and exc_busy drops after DONE.
// - Reset mid-run. Stimulus: reset asserted in WAIT.
//   Response: next cycle all outputs 0, no pc_wr pulse, and a fresh overflow restarts cleanly.
// - Latency sweep. Stimulus: MEM_WAIT=1 and MEM_WAIT=4.
//   Response: exc_busy high for 5 and 8 cycles respectively.

Source files
------------

// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception entry sequencer.
// Holds the FSM state encoding, the latched cause codes and the address-select
// codes that the address mux and the main control unit also decode.
package exception_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAVE = 3'd1,
    ST_ADDR = 3'd2,
    ST_WAIT = 3'd3,
    ST_LOAD = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned SEL_W   = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_OVF  = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_DIVZ = 2'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_OPC  = 2'd3;

  // Select codes for the vector slots 0x253 / 0x254 / 0x255
  localparam logic [SEL_W-1:0] SEL_NONE = 3'd0;
  localparam logic [SEL_W-1:0] SEL_OVF  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_DIVZ = 3'd3;
  localparam logic [SEL_W-1:0] SEL_OPC  = 3'd4;

  // Map a latched cause to the address-select code of its vector slot
  function automatic logic [SEL_W-1:0] sel_for_cause(input logic [CAUSE_W-1:0] c);
    logic [SEL_W-1:0] s;
    s = SEL_NONE;
    case (c)
      CAUSE_OVF:  s = SEL_OVF;
      CAUSE_DIVZ: s = SEL_DIVZ;
      CAUSE_OPC:  s = SEL_OPC;
      default:    s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/exception_sequencer.sv
// Exception entry sequencer.
// Latches a raised cause, saves EPC = pc_in - PC_OFFSET, reads the handler
// byte from the cause's vector slot and loads it into the PC, then hands the
// datapath back to main control.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   overflow/div_zero/bad_opcode  exception flags, sampled only in IDLE
//   pc_in                 current PC
//   mem_data              memory read data, byte [7:0] used
//   exc_busy              sequencer owns select/memory/PC
//   exc_sel               address-select code (0 when not busy)
//   mem_rd                memory read strobe
//   epc_wr, epc_out       EPC write pulse and value
//   cause                 latched cause code
//   pc_wr, pc_next        PC write pulse and zero-extended handler byte
//   exc_done              1-cycle completion pulse
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 2,
  parameter int unsigned PC_OFFSET = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic        bad_opcode,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic        exc_busy,
  output logic [2:0]  exc_sel,
  output logic        mem_rd,
  output logic        epc_wr,
  output logic [31:0] epc_out,
  output logic [1:0]  cause,
  output logic        pc_wr,
  output logic [31:0] pc_next,
  output logic        exc_done
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cause_d;
  logic [31:0]        epc_d;
  logic [31:0]        pc_next_d;
  logic               exc_busy_d, mem_rd_d, epc_wr_d, pc_wr_d, exc_done_d;
  logic [2:0]         exc_sel_d;

  // Only the handler byte is used; upper read data is intentionally ignored
  logic unused_mem_hi;
  assign unused_mem_hi = ^mem_data[31:8];

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cause    <= CAUSE_NONE;
      epc_out  <= '0;
      pc_next  <= '0;
      exc_busy <= 1'b0;
      exc_sel  <= SEL_NONE;
      mem_rd   <= 1'b0;
      epc_wr   <= 1'b0;
      pc_wr    <= 1'b0;
      exc_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause    <= cause_d;
      epc_out  <= epc_d;
      pc_next  <= pc_next_d;
      exc_busy <= exc_busy_d;
      exc_sel  <= exc_sel_d;
      mem_rd   <= mem_rd_d;
      epc_wr   <= epc_wr_d;
      pc_wr    <= pc_wr_d;
      exc_done <= exc_done_d;
    end
  end

  // Next state; outputs are decoded from the next state so the registered
  // versions line up with the state they belong to
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause;
    epc_d     = epc_out;
    pc_next_d = pc_next;

    case (state_q)
      ST_IDLE: begin
        if (overflow || div_zero || bad_opcode) begin
          state_d = ST_SAVE;
          epc_d   = pc_in - 32'(PC_OFFSET);
          if (bad_opcode)    cause_d = CAUSE_OPC;
          else if (overflow) cause_d = CAUSE_OVF;
          else               cause_d = CAUSE_DIVZ;
        end
      end
      ST_SAVE: state_d = ST_ADDR;
      ST_ADDR: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(MEM_WAIT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = ST_LOAD;
          pc_next_d = {24'b0, mem_data[7:0]};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    exc_busy_d = (state_d != ST_IDLE);
    epc_wr_d   = (state_d == ST_SAVE);
    mem_rd_d   = (state_d == ST_ADDR) || (state_d == ST_WAIT);
    pc_wr_d    = (state_d == ST_LOAD);
    exc_done_d = (state_d == ST_DONE);
    exc_sel_d  = SEL_NONE;
    if ((state_d == ST_ADDR) || (state_d == ST_WAIT) || (state_d == ST_LOAD))
      exc_sel_d = sel_for_cause(cause_d);
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer (MEM_WAIT=2 main instance, plus
// MEM_WAIT=1 and MEM_WAIT=4 instances sharing the same stimulus).
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset, overflow, div_zero, bad_opcode;
  logic [31:0] pc_in, mem_data;

  logic        exc_busy, mem_rd, epc_wr, pc_wr, exc_done;
  logic [2:0]  exc_sel;
  logic [31:0] epc_out, pc_next;
  logic [1:0]  cause;

  logic        busy1, mem_rd1, epc_wr1, pc_wr1, done1;
  logic [2:0]  sel1;
  logic [31:0] epc1, pcn1;
  logic [1:0]  cause1;

  logic        busy4, mem_rd4, epc_wr4, pc_wr4, done4;
  logic [2:0]  sel4;
  logic [31:0] epc4, pcn4;
  logic [1:0]  cause4;

  int checks   = 0;
  int failures = 0;
  int nbusy2, nbusy1, nbusy4, ndone, npcwr;

  always #5 clk = ~clk;

  exception_sequencer #(.MEM_WAIT(2), .PC_OFFSET(4)) u_dut (
    .clk(clk), .reset(reset), .overflow(overflow), .div_zero(div_zero),
    .bad_opcode(bad_opcode), .pc_in(pc_in), .mem_data(mem_data),
    .exc_busy(exc_busy), .exc_sel(exc_sel), .mem_rd(mem_rd), .epc_wr(epc_wr),
    .epc_out(epc_out), .cause(cause), .pc_wr(pc_wr), .pc_next(pc_next),
    .exc_done(exc_done)
  );

  exception_sequencer #(.MEM_WAIT(1), .PC_OFFSET(4)) u_dut_w1 (
    .clk(clk), .reset(reset), .overflow(overflow), .div_zero(div_zero),
    .bad_opcode(bad_opcode), .pc_in(pc_in), .mem_data(mem_data),
    .exc_busy(busy1), .exc_sel(sel1), .mem_rd(mem_rd1), .epc_wr(epc_wr1),
    .epc_out(epc1), .cause(cause1), .pc_wr(pc_wr1), .pc_next(pcn1),
    .exc_done(done1)
  );

  exception_sequencer #(.MEM_WAIT(4), .PC_OFFSET(4)) u_dut_w4 (
    .clk(clk), .reset(reset), .overflow(overflow), .div_zero(div_zero),
    .bad_opcode(bad_opcode), .pc_in(pc_in), .mem_data(mem_data),
    .exc_busy(busy4), .exc_sel(sel4), .mem_rd(mem_rd4), .epc_wr(epc_wr4),
    .epc_out(epc4), .cause(cause4), .pc_wr(pc_wr4), .pc_next(pcn4),
    .exc_done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=0x%08h expected=0x%08h", tag, $time, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    nbusy2 += 32'(exc_busy);
    nbusy1 += 32'(busy1);
    nbusy4 += 32'(busy4);
    ndone  += 32'(exc_done);
    npcwr  += 32'(pc_wr);
  endtask

  task automatic clear_counts();
    nbusy2 = 0; nbusy1 = 0; nbusy4 = 0; ndone = 0; npcwr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    32'(exc_busy), 32'd0);
    chk({tag, "_sel"},     32'(exc_sel),  32'd0);
    chk({tag, "_mem_rd"},  32'(mem_rd),   32'd0);
    chk({tag, "_epc_wr"},  32'(epc_wr),   32'd0);
    chk({tag, "_epc"},     epc_out,       32'd0);
    chk({tag, "_cause"},   32'(cause),    32'd0);
    chk({tag, "_pc_wr"},   32'(pc_wr),    32'd0);
    chk({tag, "_pc_next"}, pc_next,       32'd0);
    chk({tag, "_done"},    32'(exc_done), 32'd0);
  endtask

  // Flags must already be driven; walks the MEM_WAIT=2 sequence cycle by cycle
  task automatic run_seq(input logic [1:0] ec, input logic [2:0] es,
                         input logic [31:0] eepc, input logic [31:0] epcn);
    tick();
    overflow = 1'b0; div_zero = 1'b0; bad_opcode = 1'b0;
    chk("save_busy",   32'(exc_busy), 32'd1);
    chk("save_epc_wr", 32'(epc_wr),   32'd1);
    chk("save_epc",    epc_out,       eepc);
    chk("save_cause",  32'(cause),    32'(ec));
    chk("save_sel",    32'(exc_sel),  32'd0);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("seq_busy",   32'(exc_busy), 32'd1);
      chk("seq_sel",    32'(exc_sel),  (c <= 5) ? 32'(es) : 32'd0);
      chk("seq_mem_rd", 32'(mem_rd),   (c <= 4) ? 32'd1 : 32'd0);
      chk("seq_pc_wr",  32'(pc_wr),    (c == 5) ? 32'd1 : 32'd0);
      chk("seq_done",   32'(exc_done), (c == 6) ? 32'd1 : 32'd0);
      chk("seq_epc_wr", 32'(epc_wr),   32'd0);
      if (c >= 5) chk("seq_pc_next", pc_next, epcn);
    end
    tick();
    chk("post_busy",  32'(exc_busy), 32'd0);
    chk("post_sel",   32'(exc_sel),  32'd0);
    chk("post_cause", 32'(cause),    32'(ec));
    chk("post_epc",   epc_out,       eepc);
  endtask

  initial begin
    reset = 1'b1; overflow = 1'b0; div_zero = 1'b0; bad_opcode = 1'b0;
    pc_in = 32'h0; mem_data = 32'h0;
    clear_counts();

    // Reset state
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();

    // Overflow: epc 0x3C, sel 2, pc_next 0xA7, done at cycle 6; latency sweep alongside
    clear_counts();
    pc_in = 32'h40; mem_data = 32'h0000_00A7; overflow = 1'b1;
    run_seq(2'd1, 3'd2, 32'h3C, 32'hA7);
    tick(); tick(); tick();
    chk("lat_busy_w2", 32'(nbusy2), 32'd6);
    chk("lat_busy_w1", 32'(nbusy1), 32'd5);
    chk("lat_busy_w4", 32'(nbusy4), 32'd8);
    chk("lat_pc_w1",   pcn1,        32'hA7);
    chk("lat_pc_w4",   pcn4,        32'hA7);
    chk("ovf_done_n",  32'(ndone),  32'd1);
    chk("ovf_pcwr_n",  32'(npcwr),  32'd1);

    // Simultaneous flags: bad_opcode wins, sel 4
    pc_in = 32'h100; mem_data = 32'h0000_0055;
    overflow = 1'b1; div_zero = 1'b1; bad_opcode = 1'b1;
    run_seq(2'd3, 3'd4, 32'hFC, 32'h55);
    tick(); tick(); tick();

    // Wrap-around EPC
    pc_in = 32'h0; mem_data = 32'hFFFF_FF12; div_zero = 1'b1;
    run_seq(2'd2, 3'd3, 32'hFFFF_FFFC, 32'h12);
    tick(); tick(); tick();

    // Flag while busy is ignored
    clear_counts();
    pc_in = 32'h20; mem_data = 32'h0000_0009; bad_opcode = 1'b1;
    tick();
    bad_opcode = 1'b0;
    tick();
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("busyflag_done_n", 32'(ndone),    32'd1);
    chk("busyflag_busy",   32'(exc_busy), 32'd0);
    chk("busyflag_cause",  32'(cause),    32'd3);
    chk("busyflag_epc",    epc_out,       32'h1C);
    tick(); tick();

    // Reset in WAIT aborts; no pc_wr; fresh overflow restarts
    clear_counts();
    pc_in = 32'h80; mem_data = 32'h0000_0077; overflow = 1'b1;
    tick();
    overflow = 1'b0;
    tick(); tick();
    chk("mid_in_wait", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("midrst_pcwr_n", 32'(npcwr),    32'd0);
    chk("midrst_idle",   32'(exc_busy), 32'd0);
    pc_in = 32'h200; mem_data = 32'h0000_0033; overflow = 1'b1;
    run_seq(2'd1, 3'd2, 32'h1FC, 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
